alu_issue: RTL and testbench

// - Issue stage directly upstream of the RV32IM ALU: accepts 32-bit ALU instructions over valid/ready,

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/alu_regfile.sv | 34 +++
 rtl/alu_issue.sv | 195 +++++++++++++++++++
 tb/tb_alu_issue.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 encodings and types for the ALU issue stage.
// Holds the ALU opcodes, the funct7 values accepted for R-type, the issue FSM state type, the
// instruction field layout and a legality helper. No ports.
package riscv_pkg;

  localparam logic [6:0] OPC_ALU_I = 7'b0010011;
  localparam logic [6:0] OPC_ALU_R = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    TRAP
  } issue_state_t;

  typedef struct packed {
    logic [6:0] f7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv_instr_t;

  // Only OP-IMM, and OP with one of the three known funct7 groups, reach the ALU.
  function automatic logic is_legal(rv_instr_t i);
    return (i.opcode == OPC_ALU_I) ||
           ((i.opcode == OPC_ALU_R) &&
            ((i.f7 == F7_BASE) || (i.f7 == F7_ALT) || (i.f7 == F7_MULDIV)));
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file for the ALU issue stage.
// Ports:
//   i_clk                      clock
//   i_we, i_waddr, i_wdata     synchronous write port; writes to index 0 are dropped
//   i_raddr_a / o_rdata_a      asynchronous read port A
//   i_raddr_b / o_rdata_b      asynchronous read port B
// Index 0 is never written; the issue stage substitutes zero for it on read.
module alu_regfile #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr_a,
  output logic [XLEN-1:0] o_rdata_a,
  input  logic [AW-1:0]   i_raddr_b,
  output logic [XLEN-1:0] o_rdata_b
);

  logic [XLEN-1:0] r_mem [NUM_REGS];

  always_ff @(posedge i_clk) begin
    if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of an RV32IM ALU.
// Accepts ALU instructions over valid/ready, reads operands (with writeback forwarding), stalls
// one cycle on a RAW hazard against the instruction just issued, drives registered ALU inputs,
// and writes the ALU's registered result back one cycle later. Non-ALU encodings trap until
// acknowledged. After reset the register file is cleared over NUM_REGS cycles.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_instr_valid, i_instr       instruction input; o_instr_ready accepts it
//   o_alu_opcode_valid           ALU inputs carry an issued instruction
//   o_alu_opcode/f3/imm          instr[6:0], instr[14:12], instr[31:20]
//   o_alu_rs1, o_alu_rs2         operand values (rs2 is 0 for I-type)
//   i_alu_result                 registered ALU result
//   o_wb_valid, o_wb_rd, o_wb_data  writeback (never for rd==0); data mirrors i_alu_result
//   o_trap, o_trap_instr, i_trap_clr  illegal-instruction trap and acknowledge pulse
//   o_init_done                  register file clear complete
module alu_issue
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_instr_valid,
  input  logic [31:0]     i_instr,
  output logic            o_instr_ready,
  output logic            o_alu_opcode_valid,
  output logic [6:0]      o_alu_opcode,
  output logic [2:0]      o_alu_f3,
  output logic [11:0]     o_alu_imm,
  output logic [XLEN-1:0] o_alu_rs1,
  output logic [XLEN-1:0] o_alu_rs2,
  input  logic [XLEN-1:0] i_alu_result,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_trap,
  output logic [31:0]     o_trap_instr,
  input  logic            i_trap_clr,
  output logic            o_init_done
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  rv_instr_t    w_instr;
  issue_state_t r_state;
  logic [4:0]   r_clr_cnt;
  logic         r_init_done;
  logic         r_trap;
  logic [31:0]  r_trap_instr;

  logic            r_alu_valid;
  logic [6:0]      r_alu_opcode;
  logic [2:0]      r_alu_f3;
  logic [11:0]     r_alu_imm;
  logic [XLEN-1:0] r_alu_rs1;
  logic [XLEN-1:0] r_alu_rs2;
  logic [4:0]      r_alu_rd;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;

  logic            w_is_r;
  logic            w_legal;
  logic            w_stall;
  logic            w_ready;
  logic            w_accept;
  logic            w_issue;
  logic [XLEN-1:0] w_rf_rdata_a;
  logic [XLEN-1:0] w_rf_rdata_b;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_rf_we;
  logic [4:0]      w_rf_waddr;
  logic [XLEN-1:0] w_rf_wdata;

  assign w_instr = i_instr;
  assign w_is_r  = (w_instr.opcode == OPC_ALU_R);
  assign w_legal = is_legal(w_instr);

  // The instruction in the issue register has no result until the ALU registers it; one bubble
  // lets it reach writeback, where forwarding picks it up.
  assign w_stall = r_alu_valid && (r_alu_rd != '0) &&
                   ((r_alu_rd == w_instr.rs1) || (w_is_r && (r_alu_rd == w_instr.rs2)));
  assign w_ready  = (r_state == RUN) && !w_stall;
  assign w_accept = i_instr_valid && w_ready;
  assign w_issue  = w_accept && w_legal;

  // Register file: cleared index by index during INIT, otherwise fed from writeback.
  assign w_rf_we    = !i_rst && ((r_state == INIT) || r_wb_valid);
  assign w_rf_waddr = (r_state == INIT) ? r_clr_cnt : r_wb_rd;
  assign w_rf_wdata = (r_state == INIT) ? '0 : i_alu_result;

  alu_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_we      (w_rf_we),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (w_instr.rs1),
    .o_rdata_a (w_rf_rdata_a),
    .i_raddr_b (w_instr.rs2),
    .o_rdata_b (w_rf_rdata_b)
  );

  // Writeback forwarding also covers the write-and-read-same-index cycle.
  always_comb begin
    w_rs1_val = w_rf_rdata_a;
    if (w_instr.rs1 == '0) begin
      w_rs1_val = '0;
    end else if (r_wb_valid && (r_wb_rd == w_instr.rs1)) begin
      w_rs1_val = i_alu_result;
    end

    w_rs2_val = '0;
    if (w_is_r && (w_instr.rs2 != '0)) begin
      if (r_wb_valid && (r_wb_rd == w_instr.rs2)) begin
        w_rs2_val = i_alu_result;
      end else begin
        w_rs2_val = w_rf_rdata_b;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= INIT;
      r_clr_cnt    <= '0;
      r_init_done  <= 1'b0;
      r_trap       <= 1'b0;
      r_trap_instr <= '0;
      r_alu_valid  <= 1'b0;
      r_alu_opcode <= '0;
      r_alu_f3     <= '0;
      r_alu_imm    <= '0;
      r_alu_rs1    <= '0;
      r_alu_rs2    <= '0;
      r_alu_rd     <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
    end else begin
      // Anything not issued becomes an all-zero bubble so the ALU produces 0.
      r_alu_valid  <= w_issue;
      r_alu_opcode <= w_issue ? w_instr.opcode : '0;
      r_alu_f3     <= w_issue ? w_instr.f3 : '0;
      r_alu_imm    <= w_issue ? {w_instr.f7, w_instr.rs2} : '0;
      r_alu_rs1    <= w_issue ? w_rs1_val : '0;
      r_alu_rs2    <= w_issue ? w_rs2_val : '0;
      r_alu_rd     <= w_issue ? w_instr.rd : '0;
      r_wb_valid   <= r_alu_valid && (r_alu_rd != '0);
      r_wb_rd      <= r_alu_rd;

      unique case (r_state)
        INIT: begin
          if (r_clr_cnt == LAST_IDX) begin
            r_state     <= RUN;
            r_init_done <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + 5'd1;
          end
        end
        RUN: begin
          if (w_accept && !w_legal) begin
            r_state      <= TRAP;
            r_trap       <= 1'b1;
            r_trap_instr <= i_instr;
          end
        end
        TRAP: begin
          if (i_trap_clr) begin
            r_state <= RUN;
            r_trap  <= 1'b0;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign o_instr_ready      = w_ready;
  assign o_alu_opcode_valid = r_alu_valid;
  assign o_alu_opcode       = r_alu_opcode;
  assign o_alu_f3           = r_alu_f3;
  assign o_alu_imm          = r_alu_imm;
  assign o_alu_rs1          = r_alu_rs1;
  assign o_alu_rs2          = r_alu_rs2;
  assign o_wb_valid         = r_wb_valid;
  assign o_wb_rd            = r_wb_rd;
  assign o_wb_data          = i_alu_result;
  assign o_trap             = r_trap;
  assign o_trap_instr       = r_trap_instr;
  assign o_init_done        = r_init_done;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        trap_clr;
  logic        ready;
  logic        av;
  logic [6:0]  aop;
  logic [2:0]  af3;
  logic [11:0] aimm;
  logic [31:0] ars1;
  logic [31:0] ars2;
  logic [31:0] alu_res;
  logic        wbv;
  logic [4:0]  wbrd;
  logic [31:0] wbd;
  logic        trp;
  logic [31:0] trpi;
  logic        initd;

  int total = 0;
  int bad   = 0;

  alu_issue #(
    .XLEN     (32),
    .NUM_REGS (32)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_instr_valid      (in_valid),
    .i_instr            (in_instr),
    .o_instr_ready      (ready),
    .o_alu_opcode_valid (av),
    .o_alu_opcode       (aop),
    .o_alu_f3           (af3),
    .o_alu_imm          (aimm),
    .o_alu_rs1          (ars1),
    .o_alu_rs2          (ars2),
    .i_alu_result       (alu_res),
    .o_wb_valid         (wbv),
    .o_wb_rd            (wbrd),
    .o_wb_data          (wbd),
    .o_trap             (trp),
    .o_trap_instr       (trpi),
    .i_trap_clr         (trap_clr),
    .o_init_done        (initd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ALU behaviour (simplified M group: f3==0 low product, otherwise high unsigned product).
  function automatic logic [31:0] alu_f(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [11:0] imm, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] bi;
    logic [6:0]  f7;
    logic [63:0] p;
    f7 = imm[11:5];
    bi = {{20{imm[11]}}, imm};
    if (opc == 7'b0010011) begin
      case (f3)
        3'd0: return a + bi;
        3'd1: return a << imm[4:0];
        3'd2: return {31'b0, $signed(a) < $signed(bi)};
        3'd3: return {31'b0, a < bi};
        3'd4: return a ^ bi;
        3'd5: return imm[10] ? 32'($signed(a) >>> imm[4:0]) : a >> imm[4:0];
        3'd6: return a | bi;
        default: return a & bi;
      endcase
    end else if (opc == 7'b0110011) begin
      if (f7 == 7'h01) begin
        p = {32'b0, a} * {32'b0, b};
        return (f3 == 3'd0) ? p[31:0] : p[63:32];
      end
      case (f3)
        3'd0: return (f7 == 7'h20) ? a - b : a + b;
        3'd1: return a << b[4:0];
        3'd2: return {31'b0, $signed(a) < $signed(b)};
        3'd3: return {31'b0, a < b};
        3'd4: return a ^ b;
        3'd5: return (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    return 32'd0;
  endfunction

  // Registered ALU downstream of the DUT.
  always @(posedge clk) alu_res <= alu_f(aop, af3, aimm, ars1, ars2);

  // ---------------- behavioural model: program-order register state + timed event queues
  typedef struct {
    int          cyc;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } iss_t;
  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] d;
  } wb_t;

  iss_t        iss_q[$];
  wb_t         wb_q[$];
  iss_t        ie;
  wb_t         we;
  int          cyc = 0;
  bit          live = 1'b0;
  int          m_mode;  // 0 clear, 1 run, 2 trap
  int          m_cnt;
  bit          m_init;
  bit          m_trap;
  logic [31:0] m_trap_instr;
  logic [31:0] m_arch [32];
  logic [31:0] res;

  function automatic bit m_legal(input logic [31:0] w);
    logic [6:0] f7;
    f7 = w[31:25];
    return (w[6:0] == 7'b0010011) ||
           ((w[6:0] == 7'b0110011) && (f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01));
  endfunction

  // Ready unless the instruction accepted last cycle writes a register this one reads.
  function automatic bit m_ready();
    logic [4:0] rd;
    if (m_mode != 1) return 1'b0;
    if (iss_q.size() > 0 && iss_q[0].cyc == cyc && iss_q[0].rd != 5'd0) begin
      rd = iss_q[0].rd;
      if (rd == in_instr[19:15]) return 1'b0;
      if (in_instr[6:0] == 7'b0110011 && rd == in_instr[24:20]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      live = 1'b1;
      m_mode = 0;
      m_cnt = 0;
      m_init = 1'b0;
      m_trap = 1'b0;
      m_trap_instr = 32'd0;
      for (int i = 0; i < 32; i++) m_arch[i] = 32'd0;
      iss_q.delete();
      wb_q.delete();
    end else if (live) begin
      case (m_mode)
        0: begin
          if (m_cnt == 31) begin
            m_mode = 1;
            m_init = 1'b1;
          end else begin
            m_cnt++;
          end
        end
        1: begin
          if (in_valid && m_ready()) begin
            if (!m_legal(in_instr)) begin
              m_mode = 2;
              m_trap = 1'b1;
              m_trap_instr = in_instr;
            end else begin
              ie.cyc = cyc + 1;
              ie.opc = in_instr[6:0];
              ie.f3  = in_instr[14:12];
              ie.imm = in_instr[31:20];
              ie.rd  = in_instr[11:7];
              ie.a   = m_arch[in_instr[19:15]];
              ie.b   = (ie.opc == 7'b0110011) ? m_arch[in_instr[24:20]] : 32'd0;
              res    = alu_f(ie.opc, ie.f3, ie.imm, ie.a, ie.b);
              iss_q.push_back(ie);
              if (ie.rd != 5'd0) begin
                we.cyc = cyc + 2;
                we.rd  = ie.rd;
                we.d   = res;
                wb_q.push_back(we);
                m_arch[ie.rd] = res;
              end
            end
          end
        end
        default: begin
          if (trap_clr) begin
            m_mode = 1;
            m_trap = 1'b0;
          end
        end
      endcase
    end
    cyc++;
    while (iss_q.size() > 0 && iss_q[0].cyc < cyc) void'(iss_q.pop_front());
    while (wb_q.size() > 0 && wb_q[0].cyc < cyc) void'(wb_q.pop_front());
  end

  // ---------------- compare process
  logic [31:0] wb_seen [32];
  int          wb_cnt = 0;
  bit          e_av;
  bit          e_wbv;
  iss_t        e_iss;

  always @(negedge clk) begin
    if (live) begin
      e_av = (iss_q.size() > 0 && iss_q[0].cyc == cyc);
      e_iss = '{cyc: 0, opc: 7'd0, f3: 3'd0, imm: 12'd0, a: 32'd0, b: 32'd0, rd: 5'd0};
      if (e_av) e_iss = iss_q[0];
      e_wbv = (wb_q.size() > 0 && wb_q[0].cyc == cyc);
      chk("instr_ready", {31'b0, ready}, {31'b0, m_ready()});
      chk("alu_valid", {31'b0, av}, {31'b0, e_av});
      chk("alu_opcode", {25'b0, aop}, {25'b0, e_iss.opc});
      chk("alu_f3", {29'b0, af3}, {29'b0, e_iss.f3});
      chk("alu_imm", {20'b0, aimm}, {20'b0, e_iss.imm});
      chk("alu_rs1", ars1, e_iss.a);
      chk("alu_rs2", ars2, e_iss.b);
      chk("wb_valid", {31'b0, wbv}, {31'b0, e_wbv});
      if (e_wbv) begin
        chk("wb_rd", {27'b0, wbrd}, {27'b0, wb_q[0].rd});
        chk("wb_data", wbd, wb_q[0].d);
      end
      chk("trap", {31'b0, trp}, {31'b0, m_trap});
      chk("trap_instr", trpi, m_trap_instr);
      chk("init_done", {31'b0, initd}, {31'b0, m_init});
      if (wbv) begin
        wb_seen[wbrd] = wbd;
        wb_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers (all start and end just after a rising edge)
  function automatic logic [31:0] ei(input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
  endfunction

  function automatic logic [31:0] er(input logic [6:0] f7, input int rs2, input int rs1,
                                     input logic [2:0] f3, input int rd);
    return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] rnd_instr();
    int         k;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    k   = int'($urandom % 16);
    rd  = 5'($urandom % 8);
    rs1 = 5'($urandom % 8);
    rs2 = 5'($urandom % 8);
    f3  = 3'($urandom);
    if (k == 0) begin
      if ($urandom % 2 == 0) return {7'h7f, rs2, rs1, f3, rd, 7'b0110011};
      return {12'($urandom), rs1, f3, rd, 7'b0000011};
    end
    if (k < 8) return {12'($urandom), rs1, f3, rd, 7'b0010011};
    case ($urandom % 3)
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'h01;
    endcase
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic issue(input logic [31:0] w, output int stalls);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_instr = 32'd0;
    chk("issue_accept", {31'b0, ok}, 32'd1);
    stalls = n - 1;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (initd) break;
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  int          s;
  int          n;
  int          c0;
  logic [31:0] acc;
  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 32'd0;
    trap_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    wait_init(n);
    chk("init_edges", n, 32);
    @(negedge clk);
    chk("ready_after_init", {31'b0, ready}, 32'd1);
    @(posedge clk);
    #1;

    // Every register reads back zero after the clear.
    for (int i = 1; i < 32; i++) wb_seen[i] = 32'hDEAD_BEEF;
    for (int i = 1; i < 32; i++) issue(er(7'h00, i, i, 3'd0, i), s);
    idle(3);
    acc = 32'd0;
    for (int i = 1; i < 32; i++) acc = acc | wb_seen[i];
    chk("regs_zero", acc, 32'd0);

    issue(ei(1, 0, 5), s);
    issue(NOP, s);
    issue(NOP, s);
    issue(ei(2, 0, 7), s);
    issue(NOP, s);
    issue(NOP, s);
    issue(er(7'h00, 2, 1, 3'd0, 3), s);
    idle(3);
    chk("x1_addi", wb_seen[1], 32'd5);
    chk("x2_addi", wb_seen[2], 32'd7);
    chk("x3_add", wb_seen[3], 32'd12);

    issue(ei(1, 0, 9), s);
    issue(ei(2, 1, 1), s);
    chk("raw_stall_cycles", s, 1);
    idle(3);
    chk("x2_after_stall", wb_seen[2], 32'd10);

    wb_seen[4] = 32'hDEAD_BEEF;
    issue(ei(1, 0, 3), s);
    issue(NOP, s);
    issue(er(7'h20, 1, 1, 3'd0, 4), s);
    chk("fwd_no_stall", s, 0);
    idle(3);
    chk("x4_sub", wb_seen[4], 32'd0);

    issue(32'h0000_0003, s);
    @(negedge clk);
    chk("trap_set", {31'b0, trp}, 32'd1);
    chk("trap_word", trpi, 32'h0000_0003);
    chk("trap_ready", {31'b0, ready}, 32'd0);
    @(posedge clk);
    #1 trap_clr = 1'b1;
    @(posedge clk);
    #1 trap_clr = 1'b0;
    @(negedge clk);
    chk("trap_cleared", {31'b0, trp}, 32'd0);
    @(posedge clk);
    #1;
    wb_seen[6] = 32'hDEAD_BEEF;
    issue(ei(6, 0, 33), s);
    chk("post_trap_stall", s, 0);
    idle(3);
    chk("x6_post_trap", wb_seen[6], 32'd33);

    wb_seen[5] = 32'hDEAD_BEEF;
    issue(ei(0, 0, 1), s);
    issue(er(7'h00, 0, 0, 3'd0, 5), s);
    idle(3);
    chk("x5_zero", wb_seen[5], 32'd0);

    // Reset while a MUL sits in the issue register.
    issue(er(7'h01, 2, 1, 3'd0, 7), s);
    rst = 1'b1;
    c0 = wb_cnt;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_init_drop", {31'b0, initd}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_init(n);
    chk("reinit_edges", n, 32);
    chk("mul_flushed", wb_cnt - c0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = (i == 1500);
      in_valid = ($urandom % 4) != 0;
      in_instr = rnd_instr();
      trap_clr = !trap_clr && ($urandom % 3 == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    trap_clr = 1'b0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
